// File: rtl/md_iter_unit.sv
// Iterative multiply/divide unit for the EX stage; owns HI/LO.
// Ports: clk, resetn, start, md_op, srca, srcb, int_req -> busy, done, hi, lo.
module md_iter_unit #(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 5
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [3:0]       md_op,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   input  logic             int_req,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CMAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int W2   = 2 * WIDTH;

   localparam logic [3:0] OP_MULT  = 4'd0;
   localparam logic [3:0] OP_MULTU = 4'd1;
   localparam logic [3:0] OP_DIV   = 4'd2;
   localparam logic [3:0] OP_DIVU  = 4'd3;
   localparam logic [3:0] OP_MTHI  = 4'd4;
   localparam logic [3:0] OP_MTLO  = 4'd5;
   localparam logic [3:0] OP_MADD  = 4'd6;
   localparam logic [3:0] OP_MADDU = 4'd7;
   localparam logic [3:0] OP_MSUB  = 4'd8;
   localparam logic [3:0] OP_MSUBU = 4'd9;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_DFIX
   } state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             done_q, done_d;
   logic [W2-1:0]    prod_q, prod_d;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             sa_q, sa_d;
   logic             sb_q, sb_d;
   logic             dz_q, dz_d;

   logic             launch;
   logic             is_mul;
   logic             is_div;
   logic             sgn_mul;
   logic             sgn_div;
   logic [W2-1:0]    a_ext;
   logic [W2-1:0]    b_ext;
   logic [W2-1:0]    prod;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [W2-1:0]    acc;
   logic [W2-1:0]    mul_res;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   rem_sub;
   logic [WIDTH-1:0] quo_fix;
   logic [WIDTH-1:0] rem_fix;

   assign busy = (state_q != S_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
         prod_q  <= '0;
         op_q    <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
         prod_q  <= prod_d;
         op_q    <= op_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         dz_q    <= dz_d;
      end
   end

   // ---------------- op decode and arithmetic ----------------
   always_comb begin
      launch  = (state_q == S_IDLE) && start && !int_req;
      is_mul  = md_op inside {OP_MULT, OP_MULTU, OP_MADD,
                              OP_MADDU, OP_MSUB, OP_MSUBU};
      is_div  = (md_op == OP_DIV) || (md_op == OP_DIVU);
      sgn_mul = md_op inside {OP_MULT, OP_MADD, OP_MSUB};
      sgn_div = (md_op == OP_DIV);

      // Sign/zero extension to 2*WIDTH makes one unsigned multiplier
      // give the right low 2*WIDTH bits for both signednesses.
      a_ext = sgn_mul ? {{WIDTH{srca[WIDTH-1]}}, srca}
                      : {{WIDTH{1'b0}}, srca};
      b_ext = sgn_mul ? {{WIDTH{srcb[WIDTH-1]}}, srcb}
                      : {{WIDTH{1'b0}}, srcb};
      prod  = a_ext * b_ext;

      a_neg = sgn_div & srca[WIDTH-1];
      b_neg = sgn_div & srcb[WIDTH-1];
      a_mag = a_neg ? -srca : srca;
      b_mag = b_neg ? -srcb : srcb;

      acc = {hi_q, lo_q};
      unique case (op_q)
         OP_MADD, OP_MADDU: mul_res = acc + prod_q;
         OP_MSUB, OP_MSUBU: mul_res = acc - prod_q;
         default:           mul_res = prod_q;
      endcase

      // One extra bit: 2*rem+1 can exceed WIDTH bits for large divisors.
      rem_sh  = {rem_q, quo_q[WIDTH-1]};
      rem_sub = rem_sh - {1'b0, dvs_q};

      quo_fix = (sa_q ^ sb_q) ? -quo_q : quo_q;
      rem_fix = sa_q ? -rem_q : rem_q;
   end

   // ---------------- next state ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (launch && is_mul)
               state_d = S_MUL;
            else if (launch && is_div)
               state_d = (srcb == '0) ? S_DFIX : S_DIV;
         end
         S_MUL: begin
            if (int_req || cnt_q == '0)
               state_d = S_IDLE;
         end
         S_DIV: begin
            if (int_req)
               state_d = S_IDLE;
            else if (cnt_q == '0)
               state_d = S_DFIX;
         end
         S_DFIX: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- datapath / outputs ----------------
   always_comb begin
      cnt_d  = cnt_q;
      hi_d   = hi_q;
      lo_d   = lo_q;
      done_d = 1'b0;
      prod_d = prod_q;
      op_d   = op_q;
      rem_d  = rem_q;
      quo_d  = quo_q;
      dvs_d  = dvs_q;
      sa_d   = sa_q;
      sb_d   = sb_q;
      dz_d   = dz_q;

      unique case (state_q)
         S_IDLE: begin
            if (launch) begin
               op_d = md_op;
               if (md_op == OP_MTHI)
                  hi_d = srca;
               if (md_op == OP_MTLO)
                  lo_d = srca;
               if (is_mul) begin
                  prod_d = prod;
                  cnt_d  = CW'(MUL_CYCLES - 1);
               end
               if (is_div) begin
                  rem_d = '0;
                  sa_d  = a_neg;
                  sb_d  = b_neg;
                  dvs_d = b_mag;
                  cnt_d = CW'(WIDTH - 1);
                  if (srcb == '0) begin
                     // Quotient slot carries srca through to HI.
                     dz_d  = 1'b1;
                     quo_d = srca;
                  end else begin
                     dz_d  = 1'b0;
                     quo_d = a_mag;
                  end
               end
            end
         end
         S_MUL: begin
            if (int_req) begin
               cnt_d = '0;
            end else if (cnt_q == '0) begin
               {hi_d, lo_d} = mul_res;
               done_d       = 1'b1;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_DIV: begin
            if (int_req) begin
               cnt_d = '0;
            end else begin
               quo_d = {quo_q[WIDTH-2:0], ~rem_sub[WIDTH]};
               rem_d = rem_sub[WIDTH] ? rem_sh[WIDTH-1:0]
                                      : rem_sub[WIDTH-1:0];
               cnt_d = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
            end
         end
         S_DFIX: begin
            dz_d = 1'b0;
            if (!int_req) begin
               done_d = 1'b1;
               if (dz_q) begin
                  hi_d = quo_q;
                  lo_d = '1;
               end else begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_md_iter_unit.sv
// Directed bench for md_iter_unit: vector table plus corner sequences.
module tb_md_iter_unit;

   localparam int MULC = 5;
   localparam int NV   = 17;

   logic        clk;
   logic        resetn;
   logic        start;
   logic [3:0]  md_op;
   logic [31:0] srca;
   logic [31:0] srcb;
   logic        int_req;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int total = 0;
   int bad   = 0;

   md_iter_unit #(.WIDTH(32), .MUL_CYCLES(MULC)) dut (
      .clk(clk), .resetn(resetn), .start(start), .md_op(md_op),
      .srca(srca), .srcb(srcb), .int_req(int_req),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          cyc;
      logic        dn;
      logic [31:0] eh;
      logic [31:0] el;
   } vec_t;

   vec_t tbl [NV];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Launch one op from idle, count busy cycles, sample done after.
   task automatic do_op(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int n,
                        output logic dn);
      @(negedge clk);
      start = 1'b1;
      md_op = op;
      srca  = a;
      srcb  = b;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
      end
      dn = done;
   endtask

   initial begin
      int   n;
      logic dn;
      logic seen;
      logic [31:0] ph, pl;

      tbl[0]  = '{4'd0, 32'hFFFFFFFD, 32'd7, MULC, 1'b1,
                  32'hFFFFFFFF, 32'hFFFFFFEB};
      tbl[1]  = '{4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, MULC, 1'b1,
                  32'hFFFFFFFE, 32'h00000001};
      tbl[2]  = '{4'd7, 32'd2, 32'd3, MULC, 1'b1,
                  32'hFFFFFFFE, 32'h00000007};
      tbl[3]  = '{4'd8, 32'd1, 32'hFFFFFFFF, MULC, 1'b1,
                  32'hFFFFFFFE, 32'h00000008};
      tbl[4]  = '{4'd6, 32'hFFFFFFFE, 32'd3, MULC, 1'b1,
                  32'hFFFFFFFE, 32'h00000002};
      tbl[5]  = '{4'd9, 32'hFFFFFFFF, 32'd2, MULC, 1'b1,
                  32'hFFFFFFFC, 32'h00000004};
      tbl[6]  = '{4'd2, 32'hFFFFFFF9, 32'd2, 33, 1'b1,
                  32'hFFFFFFFF, 32'hFFFFFFFD};
      tbl[7]  = '{4'd3, 32'd100, 32'd7, 33, 1'b1,
                  32'd2, 32'd14};
      tbl[8]  = '{4'd3, 32'd5, 32'd0, 1, 1'b1,
                  32'd5, 32'hFFFFFFFF};
      tbl[9]  = '{4'd2, 32'h80000000, 32'hFFFFFFFF, 33, 1'b1,
                  32'd0, 32'h80000000};
      tbl[10] = '{4'd2, 32'd7, 32'hFFFFFFFE, 33, 1'b1,
                  32'd1, 32'hFFFFFFFD};
      tbl[11] = '{4'd4, 32'h12345678, 32'd0, 0, 1'b0,
                  32'h12345678, 32'hFFFFFFFD};
      tbl[12] = '{4'd5, 32'hCAFEF00D, 32'd0, 0, 1'b0,
                  32'h12345678, 32'hCAFEF00D};
      tbl[13] = '{4'd2, 32'd0, 32'd0, 1, 1'b1,
                  32'd0, 32'hFFFFFFFF};
      tbl[14] = '{4'd12, 32'd9, 32'd9, 0, 1'b0,
                  32'd0, 32'hFFFFFFFF};
      tbl[15] = '{4'd1, 32'h00010000, 32'h00010000, MULC, 1'b1,
                  32'd1, 32'd0};
      tbl[16] = '{4'd3, 32'hFFFFFFFF, 32'h80000001, 33, 1'b1,
                  32'h7FFFFFFE, 32'd1};

      resetn  = 1'b0;
      start   = 1'b0;
      md_op   = 4'd0;
      srca    = '0;
      srcb    = '0;
      int_req = 1'b0;
      #12;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      @(negedge clk);
      resetn = 1'b1;

      for (int i = 0; i < NV; i++) begin
         do_op(tbl[i].op, tbl[i].a, tbl[i].b, n, dn);
         chk($sformatf("v%0d_busy", i), n, tbl[i].cyc);
         chk($sformatf("v%0d_done", i), {31'd0, dn}, {31'd0, tbl[i].dn});
         chk($sformatf("v%0d_hi", i), hi, tbl[i].eh);
         chk($sformatf("v%0d_lo", i), lo, tbl[i].el);
         @(negedge clk);
         chk($sformatf("v%0d_pulse", i), {31'd0, done}, 32'd0);
      end

      // Abort a DIV at busy cycle 10.
      ph = tbl[NV-1].eh;
      pl = tbl[NV-1].el;
      @(negedge clk);
      start = 1'b1;
      md_op = 4'd2;
      srca  = 32'd100;
      srcb  = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      chk("abort_busy10", {31'd0, busy}, 32'd1);
      int_req = 1'b1;
      @(negedge clk);
      int_req = 1'b0;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_hi", hi, ph);
      chk("abort_lo", lo, pl);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      chk("abort_nodone", {31'd0, seen}, 32'd0);
      do_op(4'd3, 32'd100, 32'd7, n, dn);
      chk("after_abort_busy", n, 33);
      chk("after_abort_lo", lo, 32'd14);
      chk("after_abort_hi", hi, 32'd2);

      // MTHI while a MULT is in flight.
      @(negedge clk);
      start = 1'b1;
      md_op = 4'd0;
      srca  = 32'd2;
      srcb  = 32'd3;
      @(negedge clk);
      md_op = 4'd4;
      srca  = 32'hDEADBEEF;
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
         start = 1'b0;
      end
      chk("mthi_busy_cyc", n, MULC);
      chk("mthi_busy_done", {31'd0, done}, 32'd1);
      chk("mthi_busy_hi", hi, 32'd0);
      chk("mthi_busy_lo", lo, 32'd6);

      // MTLO together with int_req is dropped.
      @(negedge clk);
      start   = 1'b1;
      md_op   = 4'd5;
      srca    = 32'h55AA55AA;
      int_req = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      int_req = 1'b0;
      chk("mtlo_int_lo", lo, 32'd6);
      chk("mtlo_int_busy", {31'd0, busy}, 32'd0);

      // MULT together with int_req is dropped.
      start   = 1'b1;
      md_op   = 4'd0;
      int_req = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      int_req = 1'b0;
      chk("mult_int_busy", {31'd0, busy}, 32'd0);

      // Reset in the middle of a MULTU.
      @(negedge clk);
      start = 1'b1;
      md_op = 4'd1;
      srca  = 32'd3;
      srcb  = 32'd3;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("midrst_pre_busy", {31'd0, busy}, 32'd1);
      #2 resetn = 1'b0;
      #1;
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_hi", hi, 32'd0);
      chk("midrst_lo", lo, 32'd0);
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      resetn = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      chk("midrst_nodone", {31'd0, seen}, 32'd0);
      chk("midrst_lo_after", lo, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
